// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the core load/store path and a
//   DMA/loader port. One memory command per cycle. The CPU has priority, the DMA
//   is protected against starvation by a streak counter, and a DMA burst can lock
//   the memory with i_dma_lock. Read data comes back one cycle after the grant and
//   is steered to the port that issued the read.
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   i_cpu_req/we/addr/wdata     core access request, store flag, address, store data
//   o_cpu_stall                 core request lost arbitration this cycle
//   o_cpu_rdata/o_cpu_rvalid    load data, valid one cycle after the granted load
//   i_dma_req/we/lock/addr/wdata DMA request, write flag, burst lock, address, data
//   o_dma_gnt                   DMA command accepted this cycle
//   o_dma_rdata/o_dma_rvalid    DMA read data, valid one cycle after the granted read
//   o_mem_en/we/addr/wdata      memory command
//   i_mem_rdata                 memory read data, one cycle after a read command

module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // Core port
  input  logic                     i_cpu_req,
  input  logic                     i_cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0]    i_cpu_wdata,
  output logic                     o_cpu_stall,
  output logic [DATA_WIDTH-1:0]    o_cpu_rdata,
  output logic                     o_cpu_rvalid,
  // DMA port
  input  logic                     i_dma_req,
  input  logic                     i_dma_we,
  input  logic                     i_dma_lock,
  input  logic [ADDRESS_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0]    i_dma_wdata,
  output logic                     o_dma_gnt,
  output logic [DATA_WIDTH-1:0]    o_dma_rdata,
  output logic                     o_dma_rvalid,
  // Memory port
  output logic                     o_mem_en,
  output logic                     o_mem_we,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CPU    = 2'd1;
  localparam logic [1:0] S_DMA    = 2'd2;
  localparam logic [1:0] S_DMA_LK = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]            r_state, w_state_d;
  logic [3:0]            r_streak, w_streak_d;
  logic                  w_cpu_grant, w_dma_grant;
  logic                  w_rd_issue;
  logic                  r_rd_pend;   // a read was issued last cycle
  logic                  r_rd_dma;    // destination of that read: 1 = DMA
  logic [DATA_WIDTH-1:0] r_cpu_rdata, r_dma_rdata;

  // Grant decision, in priority order: locked burst, starvation, CPU, DMA.
  always_comb begin
    w_cpu_grant = 1'b0;
    w_dma_grant = 1'b0;
    if (r_state == S_DMA_LK && i_dma_req) begin
      w_dma_grant = 1'b1;
    end else if (r_streak == LIMIT && i_dma_req) begin
      w_dma_grant = 1'b1;
    end else if (i_cpu_req) begin
      w_cpu_grant = 1'b1;
    end else if (i_dma_req) begin
      w_dma_grant = 1'b1;
    end
  end

  always_comb begin
    w_state_d = S_IDLE;
    if (w_cpu_grant) begin
      w_state_d = S_CPU;
    end else if (w_dma_grant) begin
      w_state_d = i_dma_lock ? S_DMA_LK : S_DMA;
    end
  end

  // Count consecutive CPU wins while the DMA is waiting; saturates at 15.
  always_comb begin
    w_streak_d = r_streak;
    if (!i_dma_req || w_dma_grant) begin
      w_streak_d = 4'd0;
    end else if (w_cpu_grant && r_streak != 4'hF) begin
      w_streak_d = r_streak + 4'd1;
    end
  end

  // Memory command: the winner's fields. Address/data follow the DMA when idle.
  always_comb begin
    o_mem_en    = w_cpu_grant | w_dma_grant;
    o_mem_we    = w_cpu_grant ? i_cpu_we : (w_dma_grant & i_dma_we);
    o_mem_addr  = w_cpu_grant ? i_cpu_addr : i_dma_addr;
    o_mem_wdata = w_cpu_grant ? i_cpu_wdata : i_dma_wdata;
  end

  assign o_cpu_stall = i_cpu_req & ~w_cpu_grant;
  assign o_dma_gnt   = w_dma_grant;
  assign w_rd_issue  = o_mem_en & ~o_mem_we;

  // Read return: the memory data is forwarded in the rvalid cycle and captured
  // so that rdata stays stable until the next rvalid for that port.
  assign o_cpu_rvalid = r_rd_pend & ~r_rd_dma;
  assign o_dma_rvalid = r_rd_pend & r_rd_dma;
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : r_cpu_rdata;
  assign o_dma_rdata  = o_dma_rvalid ? i_mem_rdata : r_dma_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_streak    <= 4'd0;
      r_rd_pend   <= 1'b0;
      r_rd_dma    <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state   <= w_state_d;
      r_streak  <= w_streak_d;
      r_rd_pend <= w_rd_issue;
      r_rd_dma  <= w_dma_grant;
      if (o_cpu_rvalid) begin
        r_cpu_rdata <= i_mem_rdata;
      end
      if (o_dma_rvalid) begin
        r_dma_rdata <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small synchronous memory model
//   (64 words, registered read). Each scenario task drives cycles and checks
//   the arbiter outputs against hand-computed values.

module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int checks;
  int errors;

  // Memory model, with a backdoor write port for preloading.
  logic [31:0] mem_arr [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      mem_arr[bd_idx] <= bd_data;
    end else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:2]];
    end
  end

  dmem_arbiter #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_stall (cpu_stall),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_rvalid(cpu_rvalid),
    .i_dma_req   (dma_req),
    .i_dma_we    (dma_we),
    .i_dma_lock  (dma_lock),
    .i_dma_addr  (dma_addr),
    .i_dma_wdata (dma_wdata),
    .o_dma_gnt   (dma_gnt),
    .o_dma_rdata (dma_rdata),
    .o_dma_rvalid(dma_rvalid),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    bd_we = 1; bd_idx = addr[7:2]; bd_data = data;
    tick();
    bd_we = 0;
  endtask

  task automatic test_reset();
    logic exp;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid: got %b want 0", dma_rvalid); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_dma_rdata: got %h want 0", dma_rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_stall_gnt: got %b%b want 00", cpu_stall, dma_gnt);
    end
    rst = 0;
    tick();
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h30, 32'h5A5A5A5A);

    // Locked DMA read interrupted by reset: no rvalid, lock forgotten.
    dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 32'h30;
    #1 rst = 1;
    tick();
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL midrd_dma_rvalid: got %b want 0", dma_rvalid); end
    checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL midrd_dma_rdata: got %h want 0", dma_rdata); end
    idle_inputs();
    rst = 0;
    tick();
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL midrd_dma_rvalid2: got %b want 0", dma_rvalid); end
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h3C;
    dma_req = 1; dma_we = 1; dma_addr = 32'h38;
    #1;
    checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_state_idle: got gnt=%b stall=%b want 0 0", dma_gnt, cpu_stall);
    end
    tick();
    idle_inputs();
    tick();

    // Build a streak of 3, then reset during a CPU read.
    for (int k = 0; k < 3; k++) begin
      cpu_req = 1; cpu_we = (k != 2); cpu_addr = (k == 2) ? 32'h10 : 32'h3C;
      dma_req = 1; dma_we = 1; dma_addr = 32'h38;
      if (k == 2) begin #1 rst = 1; end
      tick();
    end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL midrd_cpu_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL midrd_cpu_rdata: got %h want 0", cpu_rdata); end
    cpu_we = 1; cpu_addr = 32'h3C;
    rst = 0;
    // Streak restarts at 0: four CPU wins before the DMA gets in.
    for (int i = 0; i < 5; i++) begin
      exp = (i == 4);
      #1;
      checks++; if (dma_gnt !== exp) begin
        errors++; $display("FAIL reset_streak cyc%0d: dma_gnt got %b want %b", i, dma_gnt, exp);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_cpu_load();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL load_cmd: got en=%b we=%b addr=%h want 1 0 00000010", mem_en, mem_we, mem_addr);
    end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL load_stall_t: got %b want 0", cpu_stall); end
    tick();
    idle_inputs();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_rdata: got v=%b d=%h want 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    checks++; if (dma_rvalid !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL load_side: got dma_rvalid=%b stall=%b want 0 0", dma_rvalid, cpu_stall);
    end
    tick();
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_hold: got v=%b d=%h want 0 deadbeef", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_starve();
    logic exp;
    idle_inputs();
    tick();
    for (int i = 0; i < 10; i++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h60; cpu_wdata = i;
      dma_req = 1; dma_we = 1; dma_addr = 32'h64; dma_wdata = 32'h100 + i;
      exp = (i == 4) || (i == 9);
      #1;
      checks++; if (dma_gnt !== exp) begin
        errors++; $display("FAIL starve_gnt cyc%0d: got %b want %b", i, dma_gnt, exp);
      end
      checks++; if (cpu_stall !== exp) begin
        errors++; $display("FAIL starve_stall cyc%0d: got %b want %b", i, cpu_stall, exp);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst();
    logic        exp;
    int          beat;
    logic [31:0] exp_addr;
    for (int i = 0; i < 8; i++) begin
      beat = (i < 4) ? 0 : i - 4;
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'h55;
      dma_req = (i < 7); dma_we = 1; dma_lock = (beat < 2);
      dma_addr = 32'h40 + 4 * beat; dma_wdata = 32'hB000 + beat;
      exp = (i >= 4) && (i <= 6);
      exp_addr = exp ? 32'h40 + 4 * beat : 32'h50;
      #1;
      checks++; if (dma_gnt !== exp || cpu_stall !== exp) begin
        errors++; $display("FAIL burst_gnt cyc%0d: got gnt=%b stall=%b want %b %b", i, dma_gnt, cpu_stall, exp, exp);
      end
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr) begin
        errors++; $display("FAIL burst_cmd cyc%0d: got en=%b we=%b addr=%h want 1 1 %h", i, mem_en, mem_we, mem_addr, exp_addr);
      end
      if (exp) begin
        checks++; if (mem_wdata !== 32'hB000 + beat) begin
          errors++; $display("FAIL burst_wdata cyc%0d: got %h want %h", i, mem_wdata, 32'hB000 + beat);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_alternating();
    preload(32'h80, 32'hA1A1A1A1);
    preload(32'h84, 32'hB2B2B2B2);
    preload(32'h88, 32'hC3C3C3C3);
    preload(32'h8C, 32'hD4D4D4D4);
    idle_inputs();
    cpu_req = 1; cpu_addr = 32'h80;
    tick();
    checks++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || cpu_rdata !== 32'hA1A1A1A1) begin
      errors++; $display("FAIL alt_1: got cv=%b dv=%b cd=%h want 1 0 a1a1a1a1", cpu_rvalid, dma_rvalid, cpu_rdata);
    end
    idle_inputs(); dma_req = 1; dma_addr = 32'h84;
    tick();
    checks++; if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== 32'hB2B2B2B2) begin
      errors++; $display("FAIL alt_2: got cv=%b dv=%b dd=%h want 0 1 b2b2b2b2", cpu_rvalid, dma_rvalid, dma_rdata);
    end
    checks++; if (cpu_rdata !== 32'hA1A1A1A1) begin
      errors++; $display("FAIL alt_cpu_hold: got %h want a1a1a1a1", cpu_rdata);
    end
    idle_inputs(); cpu_req = 1; cpu_addr = 32'h88;
    tick();
    checks++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || cpu_rdata !== 32'hC3C3C3C3) begin
      errors++; $display("FAIL alt_3: got cv=%b dv=%b cd=%h want 1 0 c3c3c3c3", cpu_rvalid, dma_rvalid, cpu_rdata);
    end
    checks++; if (dma_rdata !== 32'hB2B2B2B2) begin
      errors++; $display("FAIL alt_dma_hold: got %h want b2b2b2b2", dma_rdata);
    end
    idle_inputs(); dma_req = 1; dma_addr = 32'h8C;
    tick();
    idle_inputs();
    checks++; if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== 32'hD4D4D4D4) begin
      errors++; $display("FAIL alt_4: got cv=%b dv=%b dd=%h want 0 1 d4d4d4d4", cpu_rvalid, dma_rvalid, dma_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [0:2];
    exp_data[0] = 32'hA1A1A1A1; exp_data[1] = 32'hB2B2B2B2; exp_data[2] = 32'hC3C3C3C3;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i < 3) begin cpu_req = 1; cpu_addr = 32'h80 + 4 * i; end
      tick();
      if (i < 3) begin
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_data[i]) begin
          errors++; $display("FAIL b2b_rd%0d: got v=%b d=%h want 1 %h", i, cpu_rvalid, cpu_rdata, exp_data[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_store_load();
    idle_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
      errors++; $display("FAIL store_cmd: got en=%b we=%b addr=%h wd=%h want 1 1 00000020 00001234",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    cpu_we = 0; cpu_wdata = 0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL store_no_rvalid: got cv=%b dv=%b we=%b want 0 0 0", cpu_rvalid, dma_rvalid, mem_we);
    end
    tick();
    idle_inputs();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234) begin
      errors++; $display("FAIL store_load: got v=%b d=%h want 1 00001234", cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bd_we = 0; bd_idx = 0; bd_data = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_cpu_load();
    test_starve();
    test_burst();
    test_alternating();
    test_back_to_back();
    test_store_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
